// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter: VGA-priority arbiter sharing one single-port tile RAM with a queued game writer and a game reader.
// Optional TILE_ARB_VBLANK_ONLY_EN restricts game grants (drain and reads) to the blanking interval.
module tile_mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int WQ_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_vid_active,
  input  logic                      i_vga_req,
  input  logic [ADDR_W-1:0]         i_vga_addr,
  output logic [DATA_W-1:0]         o_vga_data,
  output logic                      o_vga_valid,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic                      i_rd_valid,
  output logic                      o_rd_ready,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_rd_rvalid,
  output logic [ADDR_W-1:0]         o_ram_addr,
  output logic                      o_ram_we,
  output logic [DATA_W-1:0]         o_ram_wdata,
  input  logic [DATA_W-1:0]         i_ram_rdata,
  output logic [$clog2(WQ_DEPTH):0] o_wq_count
);
  localparam int PW = $clog2(WQ_DEPTH);
  typedef enum logic [1:0] {IDLE, VGA, WR, RD} owner_t;
  owner_t own, own_d;
  logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
  logic [DATA_W-1:0] q_data [WQ_DEPTH];
  logic [PW-1:0] wp, rp;
  logic full, empty, allow, push, pop, vga_v, rd_v;
  logic [DATA_W-1:0] vga_hold, rd_hold;
`ifdef TILE_ARB_VBLANK_ONLY_EN
  assign allow = !i_vid_active;
`else
  logic vid_unused;
  assign allow = 1'b1;
  assign vid_unused = i_vid_active;
`endif
  always_comb begin
    full = o_wq_count == (PW+1)'(WQ_DEPTH);
    empty = o_wq_count == '0;
    push = i_wr_valid && !full;
    own_d = i_vga_req ? VGA : (!empty && allow) ? WR : (i_rd_valid && empty && allow) ? RD : IDLE;
    pop = own_d == WR;
  end
  assign o_wr_ready = !full;
  assign o_rd_ready = !i_vga_req && empty && !pop && allow;
  assign o_vga_valid = vga_v;
  assign o_rd_rvalid = rd_v;
  // RAM data arrives the cycle the valid pulse is up; the hold registers keep it afterwards
  assign o_vga_data = vga_v ? i_ram_rdata : vga_hold;
  assign o_rd_data = rd_v ? i_ram_rdata : rd_hold;
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wp] <= i_wr_addr;
      q_data[wp] <= i_wr_data;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      own <= IDLE;
      wp <= '0;
      rp <= '0;
      o_wq_count <= '0;
      o_ram_addr <= '0;
      o_ram_we <= 1'b0;
      o_ram_wdata <= '0;
      vga_v <= 1'b0;
      rd_v <= 1'b0;
      vga_hold <= '0;
      rd_hold <= '0;
    end else begin
      own <= own_d;
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      o_wq_count <= o_wq_count + (PW+1)'(push) - (PW+1)'(pop);
      o_ram_addr <= own_d == VGA ? i_vga_addr : own_d == WR ? q_addr[rp] : own_d == RD ? i_rd_addr : o_ram_addr;
      o_ram_we <= pop;
      o_ram_wdata <= pop ? q_data[rp] : o_ram_wdata;
      vga_v <= own == VGA;
      rd_v <= own == RD;
      vga_hold <= o_vga_data;
      rd_hold <= o_rd_data;
    end
  end
endmodule

// File: tb/tb_tile_mem_arbiter.sv
// tb_tile_mem_arbiter: directed scenarios plus randomized traffic against a queue/array reference model of tile_mem_arbiter.
module tb_tile_mem_arbiter;
  localparam int AW = 5, DW = 4, D = 4, CW = $clog2(D) + 1;
  logic clk = 0, rst = 1, vid_active = 0, vga_req = 0, wr_valid = 0, rd_valid = 0;
  logic [AW-1:0] vga_addr = 0, wr_addr = 0, rd_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic [DW-1:0] vga_data, rd_data, ram_wdata, ram_rdata;
  logic vga_valid, wr_ready, rd_ready, rd_rvalid, ram_we;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] wq_count;
  logic [DW-1:0] ram [2**AW];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  tile_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_vid_active(vid_active),
    .i_vga_req(vga_req), .i_vga_addr(vga_addr), .o_vga_data(vga_data), .o_vga_valid(vga_valid),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_rvalid(rd_rvalid), .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_wq_count(wq_count)
  );

  // synchronous read-first single-port RAM, one cycle of read latency
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t q[$];
  logic [DW-1:0] mm [2**AW];
  int g, pg, e_kind, e_count;
  logic [DW-1:0] gd, pgd, e_vga_hold, e_rd_hold, e_wdata;
  logic [AW-1:0] e_addr;
  logic e_we, e_rd_ready, s_rd_ready, e_wr_ready, s_wr_ready, acc;

  // one clock of the reference model: g = slot winner (0 idle, 1 vga, 2 write, 3 read)
  task automatic step();
    logic allow, full;
    wr_t w;
    #1;
`ifdef TILE_ARB_VBLANK_ONLY_EN
    allow = !vid_active;
`else
    allow = 1'b1;
`endif
    s_rd_ready = rd_ready;
    s_wr_ready = wr_ready;
    full = q.size() == D;
    e_wr_ready = !full;
    e_rd_ready = !vga_req && q.size() == 0 && allow;
    acc = wr_valid && !full && !rst;
    g = 0;
    gd = '0;
    if (rst) q.delete();
    else begin
      if (vga_req) begin g = 1; gd = mm[vga_addr]; e_addr = vga_addr; end
      else if (q.size() > 0 && allow) begin
        g = 2; w = q.pop_front(); mm[w.a] = w.d; e_addr = w.a; e_wdata = w.d;
      end else if (rd_valid && allow) begin g = 3; gd = mm[rd_addr]; e_addr = rd_addr; end
      if (acc) q.push_back({wr_addr, wr_data});
    end
    @(posedge clk);
    #1;
    e_kind = rst ? 0 : pg;
    if (rst) begin e_vga_hold = '0; e_rd_hold = '0; e_addr = '0; e_wdata = '0; end
    if (e_kind == 1) e_vga_hold = pgd;
    if (e_kind == 3) e_rd_hold = pgd;
    e_we = g == 2;
    e_count = q.size();
    pg = g;
    pgd = gd;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    n_tests++; if (wq_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", wq_count); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", ram_we); end
    n_tests++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
    n_tests++; if (ram_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", ram_wdata); end
    n_tests++; if (vga_valid !== 1'b0 || rd_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b want 00", vga_valid, rd_rvalid); end
    n_tests++; if (vga_data !== '0 || rd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", vga_data, rd_data); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 2**AW; a++) begin
      wr_valid = 1;
      wr_addr = AW'(a);
      wr_data = a == 3 ? 4'hC : a == 7 ? 4'hA : DW'($urandom);
      step();
      n_tests++; if (s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 1", a, s_wr_ready); end
      if (a > 0) begin
        n_tests++; if (ram_we !== 1'b1 || ram_addr !== AW'(a - 1)) begin n_fail++; $display("FAIL fill_drain[%0d]: got we=%b addr=%0d want we=1 addr=%0d", a, ram_we, ram_addr, a - 1); end
      end
    end
    wr_valid = 0;
    repeat (3) step();
    n_tests++; if (wq_count !== '0) begin n_fail++; $display("FAIL fill_empty: got %0d want 0", wq_count); end
  endtask

  task automatic test_vga_latency();
    vga_req = 1;
    vga_addr = 7;
    step();
    vga_req = 0;
    n_tests++; if (ram_addr !== 5'd7 || ram_we !== 1'b0) begin n_fail++; $display("FAIL vga_c1: got addr=%0d we=%b want addr=7 we=0", ram_addr, ram_we); end
    n_tests++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL vga_c1_valid: got %b want 0", vga_valid); end
    step();
    n_tests++; if (vga_valid !== 1'b1 || vga_data !== 4'hA) begin n_fail++; $display("FAIL vga_c2: got valid=%b data=%h want 1/a", vga_valid, vga_data); end
    step();
    n_tests++; if (vga_valid !== 1'b0 || vga_data !== 4'hA) begin n_fail++; $display("FAIL vga_c3: got valid=%b data=%h want 0/a", vga_valid, vga_data); end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d [5];
    vga_req = 1;
    vga_addr = 1;
    for (int i = 0; i < 5; i++) begin
      d[i] = DW'($urandom);
      wr_valid = 1;
      wr_addr = AW'(8 + i);
      wr_data = d[i];
      step();
      n_tests++; if (s_wr_ready !== (i < 4)) begin n_fail++; $display("FAIL full_ready[%0d]: got %b want %b", i, s_wr_ready, i < 4); end
    end
    wr_valid = 0;
    n_tests++; if (wq_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", wq_count); end
    vga_req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (ram_we !== 1'b1 || ram_addr !== AW'(8 + i) || ram_wdata !== d[i]) begin n_fail++; $display("FAIL full_drain[%0d]: got we=%b addr=%0d data=%h want 1/%0d/%h", i, ram_we, ram_addr, ram_wdata, 8 + i, d[i]); end
    end
    step();
    n_tests++; if (ram_we !== 1'b0 || wq_count !== '0) begin n_fail++; $display("FAIL full_done: got we=%b count=%0d want 0/0", ram_we, wq_count); end
  endtask

  task automatic test_raw();
    wr_valid = 1;
    wr_addr = 3;
    wr_data = 5;
    step();
    wr_valid = 0;
    rd_valid = 1;
    rd_addr = 3;
    step();
    n_tests++; if (s_rd_ready !== 1'b0) begin n_fail++; $display("FAIL raw_blocked: got ready=%b want 0", s_rd_ready); end
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 5'd3) begin n_fail++; $display("FAIL raw_retire: got we=%b addr=%0d want 1/3", ram_we, ram_addr); end
    for (int k = 0; k < 4 && rd_valid; k++) begin
      step();
      if (s_rd_ready) rd_valid = 0;
    end
    n_tests++; if (rd_valid) begin n_fail++; $display("FAIL raw_accept: got no accept want accept within 4 cycles"); end
    rd_valid = 0;
    step();
    n_tests++; if (rd_rvalid !== 1'b1 || rd_data !== 4'h5) begin n_fail++; $display("FAIL raw_data: got valid=%b data=%h want 1/5", rd_rvalid, rd_data); end
  endtask

  task automatic test_priority();
    vga_req = 1;
    vga_addr = 2;
    wr_valid = 1;
    wr_addr = 12;
    wr_data = 9;
    step();
    wr_valid = 0;
    rd_valid = 1;
    rd_addr = 12;
    step();
    n_tests++; if (ram_addr !== 5'd2 || ram_we !== 1'b0 || s_rd_ready !== 1'b0) begin n_fail++; $display("FAIL prio_vga: got addr=%0d we=%b rdy=%b want 2/0/0", ram_addr, ram_we, s_rd_ready); end
    vga_req = 0;
    step();
    n_tests++; if (ram_addr !== 5'd12 || ram_we !== 1'b1 || s_rd_ready !== 1'b0) begin n_fail++; $display("FAIL prio_wr: got addr=%0d we=%b rdy=%b want 12/1/0", ram_addr, ram_we, s_rd_ready); end
    step();
    rd_valid = 0;
    n_tests++; if (ram_addr !== 5'd12 || ram_we !== 1'b0 || s_rd_ready !== 1'b1) begin n_fail++; $display("FAIL prio_rd: got addr=%0d we=%b rdy=%b want 12/0/1", ram_addr, ram_we, s_rd_ready); end
    step();
    n_tests++; if (rd_rvalid !== 1'b1 || rd_data !== 4'h9) begin n_fail++; $display("FAIL prio_rdata: got valid=%b data=%h want 1/9", rd_rvalid, rd_data); end
  endtask

  task automatic test_vid_active();
    logic exp_we;
`ifdef TILE_ARB_VBLANK_ONLY_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    vga_req = 1;
    vid_active = 1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1;
      wr_addr = AW'(20 + i);
      wr_data = DW'(i + 1);
      step();
    end
    wr_valid = 0;
    vga_req = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (ram_we !== exp_we) begin n_fail++; $display("FAIL vid_hold[%0d]: got we=%b want %b", i, ram_we, exp_we); end
    end
    vid_active = 0;
`ifdef TILE_ARB_VBLANK_ONLY_EN
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (ram_we !== 1'b1 || ram_addr !== AW'(20 + i)) begin n_fail++; $display("FAIL vid_drain[%0d]: got we=%b addr=%0d want 1/%0d", i, ram_we, ram_addr, 20 + i); end
    end
`endif
    step();
    n_tests++; if (wq_count !== '0) begin n_fail++; $display("FAIL vid_empty: got %0d want 0", wq_count); end
  endtask

  task automatic test_reset_mid();
    vga_req = 1;
    vga_addr = 7;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1;
      wr_addr = AW'(i);
      wr_data = DW'($urandom);
      step();
    end
    wr_valid = 0;
    vga_req = 0;
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (wq_count !== '0 || vga_valid !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset[%0d]: got count=%0d vv=%b we=%b want 0/0/0", i, wq_count, vga_valid, ram_we); end
      step();
    end
  endtask

  task automatic test_random();
    rd_valid = 0;
    for (int i = 0; i < 400; i++) begin
      vga_req = $urandom_range(0, 2) == 0;
      vga_addr = AW'($urandom);
      vid_active = $urandom_range(0, 3) == 0;
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      if (!rd_valid && $urandom_range(0, 2) == 0) begin rd_valid = 1; rd_addr = AW'($urandom); end
      step();
      if (g == 3) rd_valid = 0;
      n_tests++; if (s_rd_ready !== e_rd_ready) begin n_fail++; $display("FAIL rnd_rd_ready[%0d]: got %b want %b", i, s_rd_ready, e_rd_ready); end
      n_tests++; if (s_wr_ready !== e_wr_ready) begin n_fail++; $display("FAIL rnd_wr_ready[%0d]: got %b want %b", i, s_wr_ready, e_wr_ready); end
      n_tests++; if (ram_we !== e_we || ram_addr !== e_addr || ram_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_ram[%0d]: got %b/%0d/%h want %b/%0d/%h", i, ram_we, ram_addr, ram_wdata, e_we, e_addr, e_wdata); end
      n_tests++; if (vga_valid !== (e_kind == 1) || vga_data !== e_vga_hold) begin n_fail++; $display("FAIL rnd_vga[%0d]: got %b/%h want %b/%h", i, vga_valid, vga_data, e_kind == 1, e_vga_hold); end
      n_tests++; if (rd_rvalid !== (e_kind == 3) || rd_data !== e_rd_hold) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %b/%h want %b/%h", i, rd_rvalid, rd_data, e_kind == 3, e_rd_hold); end
      n_tests++; if (wq_count !== CW'(e_count)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, wq_count, e_count); end
    end
    vga_req = 0;
    wr_valid = 0;
    rd_valid = 0;
    vid_active = 0;
    repeat (6) step();
    n_tests++; if (wq_count !== '0) begin n_fail++; $display("FAIL rnd_drain: got %0d want 0", wq_count); end
  endtask

  initial begin
    pg = 0;
    pgd = '0;
    test_reset();
    test_fill();
    test_vga_latency();
    test_fifo_full();
    test_raw();
    test_priority();
    test_vid_active();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Shares one single-port tile-map RAM among three requesters: the VGA renderer (tile lookup per pixel group), the klotski game-logic writer (board updates) and the game-logic reader (board queries).
- The VGA port has absolute priority and is never stalled.
- Game writes are buffered in a small FIFO and drained into free RAM slots.
- Sits between the game FSM, the vga block and the tile RAM instance.

Parameters:
- ADDR_W, 5, tile address width (4x5 board = 20 cells used).
- DATA_W, 4, tile entry width (piece id).
- WQ_DEPTH, 4, write FIFO depth (power of two, >= 2).

Ports:
- i_clk  in  1  system clock (CLOCK_50 domain)
- i_rst  in  1  synchronous, active-high reset
- i_vid_active  in  1  1 = VGA in visible region
- i_vga_req  in  1  VGA read strobe, one read per asserted cycle, always accepted
- i_vga_addr  in  ADDR_W  VGA read address
- o_vga_data  out  DATA_W  VGA read data
- o_vga_valid  out  1  o_vga_data valid
- i_wr_valid  in  1  game write request
- o_wr_ready  out  1  write accepted when valid&ready
- i_wr_addr  in  ADDR_W  write address
- i_wr_data  in  DATA_W  write data
- i_rd_valid  in  1  game read request, held until accepted
- o_rd_ready  out  1  read accepted when valid&ready
- i_rd_addr  in  ADDR_W  game read address
- o_rd_data  out  DATA_W  game read data
- o_rd_rvalid  out  1  o_rd_data valid
- o_ram_addr  out  ADDR_W  RAM address (registered)
- o_ram_we  out  1  RAM write enable (registered)
- o_ram_wdata  out  DATA_W  RAM write data (registered)
- i_ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after address
- o_wq_count  out  $clog2(WQ_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous, on i_rst=1 at a clock edge:
  - FIFO flushed (pending writes discarded); o_wq_count=0.
  - o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_vga_valid=0, o_rd_rvalid=0, o_vga_data=0, o_rd_data=0.
  - Slot owner register = IDLE.
  - A read issued before reset never produces a valid pulse afterwards.
- Arbitration happens each cycle t and is registered into an owner register {IDLE, VGA, WR, RD} plus o_ram_*.
- Priority:
  1. VGA if i_vga_req.
  2. WR if FIFO non-empty.
  3. RD if i_rd_valid && FIFO empty.
  4. Otherwise IDLE.
- Cycle t+1: o_ram_addr/o_ram_we/o_ram_wdata reflect the winner. o_ram_we=1 only for owner WR, which pops one FIFO entry at the t edge.
- Cycle t+2: the RAM returns data.
  - Owner-pipeline VGA at t+1 gives o_vga_valid=1 with o_vga_data=i_ram_rdata.
  - Owner RD gives o_rd_rvalid=1 with o_rd_data=i_ram_rdata.
  - Valid outputs are single-cycle pulses; data holds its last value otherwise.
- Fixed latencies: VGA request to valid is exactly 2 cycles. Game read accept to rvalid is exactly 2 cycles.
- Ready signals:
  - o_wr_ready = !full. When the FIFO is full, ready stays low even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - o_rd_ready = !i_vga_req && FIFO empty && !pop_this_cycle.
- Read-after-write coherency: a game read waits until all buffered writes have reached the RAM, so it always returns the newest data.
- FIFO ordering:
  - Writes retire in order; pointers wrap modulo WQ_DEPTH.
  - Duplicate addresses are not merged; the last write wins.
- Starvation: continuous i_vga_req starves WR and RD indefinitely (by design). The game FSM relies on blanking intervals to make progress.
- A VGA strobe during a slot already occupied by a WR does not interfere; arbitration is per cycle.

Optional Feature:
- Macro TILE_ARB_VBLANK_ONLY_EN.
- When defined:
  - FIFO drain (WR grants) and RD grants are allowed only when i_vid_active=0. This gives tear-free board updates.
  - o_rd_ready additionally requires i_vid_active=0.
  - Writes still enqueue during active video until the FIFO is full.
- When undefined: grants follow the plain priority rule regardless of i_vid_active.

Test Plan:
1. Reset mid-traffic:
   - Stimulus: 3 writes queued, VGA read in flight, then i_rst=1 for 1 cycle.
   - Response: o_wq_count=0, o_vga_valid=0 on the following 3 cycles, o_ram_we=0.
2. VGA latency:
   - Stimulus: i_vga_req=1, addr=7 at cycle 0; RAM[7]=4'hA.
   - Response: o_ram_addr=7 at cycle 1; o_vga_valid=1 and o_vga_data=A at cycle 2; no other valid pulses.
3. FIFO full:
   - Stimulus: i_vga_req held high, 5 back-to-back writes.
   - Response: first 4 accepted, o_wr_ready=0 on the 5th, o_wq_count=4.
   - Then release i_vga_req: 4 consecutive cycles with o_ram_we=1, in original order.
4. Read-after-write:
   - Stimulus: write addr 3 = 5, then immediately i_rd_valid addr 3.
   - Response: o_rd_ready stays low until the write retires; o_rd_rvalid returns 5, never the stale value.
5. Priority:
   - Stimulus: same cycle i_vga_req, FIFO non-empty, i_rd_valid.
   - Response: slot sequence is VGA, WR, then RD once the FIFO is empty and VGA is idle.
6. TILE_ARB_VBLANK_ONLY_EN build:
   - Stimulus: i_vid_active=1 with 2 queued writes.
   - Response: no o_ram_we. After i_vid_active falls: writes on the next 2 slots.
